avalon_pio_out_pulse: RTL and testbench

//  Parametrised Avalon-MM output PIO for board control lines (LCD/I2C chip selects, resets, enables).

---
 rtl/pio_pkg.sv | 23 ++
 rtl/pio_pulse_timer.sv | 74 +++++++
 rtl/avalon_pio_out_pulse.sv | 105 ++++++++++
 tb/tb_avalon_pio_out_pulse.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared register map, status bit positions and pulse FSM encoding for the
// Avalon-MM output PIO with one-shot pulses.
package pio_pkg;

    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned BUS_WIDTH  = 32;

    localparam logic [ADDR_WIDTH-1:0] PIO_DATA      = 3'd0;
    localparam logic [ADDR_WIDTH-1:0] PIO_STATUS    = 3'd1;
    localparam logic [ADDR_WIDTH-1:0] PIO_PULSE_LEN = 3'd2;
    localparam logic [ADDR_WIDTH-1:0] PIO_PULSE     = 3'd3;
    localparam logic [ADDR_WIDTH-1:0] PIO_OUTSET    = 3'd4;
    localparam logic [ADDR_WIDTH-1:0] PIO_OUTCLEAR  = 3'd5;

    localparam int unsigned STATUS_BUSY_BIT    = 0;
    localparam int unsigned STATUS_OVERRUN_BIT = 1;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/pio_pulse_timer.sv
// One-shot pulse timer: holds an inversion mask for a programmed number of
// cycles, then clears it. Exposes the next-cycle mask so the pin flop aligns.
module pio_pulse_timer
    import pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_start_mask,
    input  logic [CNT_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_overrun_set_c,
    output logic [DATA_WIDTH-1:0] o_mask_next_c
);

    pulse_state_t          r_state;
    pulse_state_t          w_state_next;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_next;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] w_mask_next;
    logic                  w_overrun_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PULSE_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_mask  <= w_mask_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_mask_next   = r_mask;
        w_overrun_set = 1'b0;
        case (r_state)
            PULSE_IDLE: begin
                // A zero length request is dropped silently.
                if (i_start && (i_len != '0)) begin
                    w_state_next = PULSE_ACTIVE;
                    w_cnt_next   = i_len;
                    w_mask_next  = i_start_mask;
                end
            end
            PULSE_ACTIVE: begin
                w_cnt_next    = r_cnt - CNT_WIDTH'(1);
                w_overrun_set = i_start;
                if (r_cnt <= CNT_WIDTH'(1)) begin
                    w_state_next = PULSE_IDLE;
                    w_cnt_next   = '0;
                    w_mask_next  = '0;
                end
            end
            default: begin
                w_state_next = PULSE_IDLE;
                w_cnt_next   = '0;
                w_mask_next  = '0;
            end
        endcase
    end

    assign o_busy          = (r_state == PULSE_ACTIVE);
    assign o_overrun_set_c = w_overrun_set;
    assign o_mask_next_c   = w_mask_next;

endmodule

// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM zero-wait-state output PIO with atomic set/clear and hardware
// one-shot pulses; out_port is a single flop of data ^ pulse mask.
module avalon_pio_out_pulse
    import pio_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter int unsigned          CNT_WIDTH     = 16,
    parameter logic [CNT_WIDTH-1:0] PULSE_LEN_RST = CNT_WIDTH'(100)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [BUS_WIDTH-1:0]  writedata,
    output logic [BUS_WIDTH-1:0]  readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wd_data;
    logic [CNT_WIDTH-1:0]  w_wd_len;
    logic                  w_unused_wd;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic [CNT_WIDTH-1:0]  r_len;
    logic                  r_overrun;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  w_busy;
    logic                  w_overrun_set;
    logic [DATA_WIDTH-1:0] w_mask_next;
    logic [BUS_WIDTH-1:0]  w_status;

    assign w_wr        = chipselect & ~write_n;
    assign w_wd_data   = writedata[DATA_WIDTH-1:0];
    assign w_wd_len    = writedata[CNT_WIDTH-1:0];
    assign w_unused_wd = ^writedata;

    pio_pulse_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_timer (
        .clk             (clk),
        .reset           (reset),
        .i_start         (w_wr && (address == PIO_PULSE)),
        .i_start_mask    (w_wd_data),
        .i_len           (r_len),
        .o_busy          (w_busy),
        .o_overrun_set_c (w_overrun_set),
        .o_mask_next_c   (w_mask_next)
    );

    always_comb begin
        w_data_next = r_data;
        if (w_wr) begin
            case (address)
                PIO_DATA:     w_data_next = w_wd_data;
                PIO_OUTSET:   w_data_next = r_data | w_wd_data;
                PIO_OUTCLEAR: w_data_next = r_data & ~w_wd_data;
                default:      w_data_next = r_data;
            endcase
        end
    end

    // Pins load the same next-state as data, so pulsed bits track data edits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= RESET_VALUE;
            r_out     <= RESET_VALUE;
            r_len     <= PULSE_LEN_RST;
            r_overrun <= 1'b0;
        end else begin
            r_data <= w_data_next;
            r_out  <= w_data_next ^ w_mask_next;
            if (w_wr && (address == PIO_PULSE_LEN)) begin
                r_len <= w_wd_len;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_wr && (address == PIO_STATUS) && writedata[STATUS_OVERRUN_BIT]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status                     = '0;
        w_status[STATUS_BUSY_BIT]    = w_busy;
        w_status[STATUS_OVERRUN_BIT] = r_overrun;
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_DATA:      readdata = BUS_WIDTH'(r_data);
            PIO_STATUS:    readdata = w_status;
            PIO_PULSE_LEN: readdata = BUS_WIDTH'(r_len);
            default:       readdata = '0;
        endcase
    end

    assign out_port = r_out;

endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// Directed scoreboard bench for avalon_pio_out_pulse (RESET_VALUE = 8'hA5).
module tb_avalon_pio_out_pulse;

    localparam logic [2:0] A_DATA = 3'd0, A_STATUS = 3'd1, A_LEN = 3'd2,
                           A_PULSE = 3'd3, A_SET = 3'd4, A_CLR = 3'd5, A_RSV = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    avalon_pio_out_pulse #(
        .DATA_WIDTH    (8),
        .RESET_VALUE   (8'hA5),
        .CNT_WIDTH     (16),
        .PULSE_LEN_RST (16'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%h required=<queued entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // One bus write; expected pins after the sampling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d, input string t, input logic [7:0] exp_out);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        push(t, 32'(exp_out));
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        pop_check(32'(out_port));
    endtask

    task automatic tick(input string t, input logic [7:0] exp_out);
        push(t, 32'(exp_out));
        @(posedge clk);
        #1;
        pop_check(32'(out_port));
    endtask

    task automatic rd(input logic [2:0] a, input string t, input logic [31:0] exp_rd);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        push(t, exp_rd);
        #1;
        pop_check(readdata);
        chipselect = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset values
        #12;
        push("rst_out_during", 32'h0000_00A5);
        pop_check(32'(out_port));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push("rst_out_after", 32'h0000_00A5);
        pop_check(32'(out_port));
        rd(A_DATA,   "rst_rd_data",   32'h0000_00A5);
        rd(A_STATUS, "rst_rd_status", 32'h0);
        rd(A_LEN,    "rst_rd_len",    32'd100);

        // Data / set / clear on consecutive edges
        wr(A_DATA, 32'hFFFF_FFF0, "wr_data",   8'hF0);
        wr(A_SET,  32'h0000_000F, "wr_outset", 8'hFF);
        wr(A_CLR,  32'h0000_0081, "wr_outclr", 8'h7E);
        rd(A_DATA, "rd_data_7e", 32'h0000_007E);

        // Reserved and write-only offsets
        wr(A_RSV, 32'hFFFF_FFFF, "wr_reserved", 8'h7E);
        rd(A_RSV,   "rd_reserved", 32'h0);
        rd(A_PULSE, "rd_pulse_wo", 32'h0);
        rd(A_SET,   "rd_outset_wo", 32'h0);
        rd(A_DATA,  "rd_data_after_rsv", 32'h0000_007E);

        // Three-cycle pulse on bit 0
        wr(A_DATA,  32'h0, "wr_data_zero", 8'h00);
        wr(A_LEN,   32'h3, "wr_len3",      8'h00);
        rd(A_LEN,   "rd_len3", 32'd3);
        wr(A_PULSE, 32'h1, "pulse_c1", 8'h01);
        rd(A_STATUS, "busy_c1", 32'h1);
        tick("pulse_c2", 8'h01);
        rd(A_STATUS, "busy_c2", 32'h1);
        tick("pulse_c3", 8'h01);
        rd(A_STATUS, "busy_c3", 32'h1);
        tick("pulse_end", 8'h00);
        rd(A_STATUS, "busy_end", 32'h0);

        // Overrun: second PULSE while active is ignored
        wr(A_PULSE, 32'h2, "ovr_pulse", 8'h02);
        wr(A_PULSE, 32'h4, "ovr_ignored", 8'h02);
        rd(A_STATUS, "ovr_status3", 32'h3);
        tick("ovr_c3", 8'h02);
        tick("ovr_end", 8'h00);
        rd(A_STATUS, "ovr_sticky", 32'h2);
        wr(A_STATUS, 32'h2, "w1c_write", 8'h00);
        rd(A_STATUS, "w1c_cleared", 32'h0);

        // Set during pulse: bit stays inverted relative to new data
        wr(A_PULSE, 32'h1, "mid_pulse", 8'h01);
        wr(A_SET,   32'h1, "mid_outset", 8'h00);
        tick("mid_c3", 8'h00);
        tick("mid_end", 8'h01);
        rd(A_DATA,   "mid_rd_data", 32'h1);
        rd(A_STATUS, "mid_status", 32'h0);

        // Zero length pulse is ignored
        wr(A_LEN,   32'h0,  "wr_len0", 8'h01);
        wr(A_PULSE, 32'hFF, "len0_pulse", 8'h01);
        rd(A_STATUS, "len0_status", 32'h0);
        tick("len0_hold", 8'h01);

        // Reset mid-pulse
        wr(A_LEN,   32'h3, "rst_len3",  8'h01);
        wr(A_PULSE, 32'h1, "rst_pulse", 8'h00);
        tick("rst_pulse_c2", 8'h00);
        reset = 1'b1;
        #1;
        push("rst_mid_out", 32'h0000_00A5);
        pop_check(32'(out_port));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push("rst_mid_after", 32'h0000_00A5);
        pop_check(32'(out_port));
        rd(A_STATUS, "rst_mid_status", 32'h0);
        rd(A_LEN,    "rst_mid_len",    32'd100);
        tick("rst_mid_hold1", 8'hA5);
        tick("rst_mid_hold2", 8'hA5);
        rd(A_DATA,   "rst_mid_data",   32'h0000_00A5);

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
